suspend_ack_ctrl: RTL and testbench



---
 rtl/suspend_ack_ctrl_pkg.sv | 29 ++
 rtl/suspend_ack_ctrl_if.sv | 25 ++
 rtl/suspend_ack_ctrl_sreq_sync.sv | 26 ++
 rtl/suspend_ack_ctrl.sv | 154 +++++++++++++++
 tb/tb_suspend_ack_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/suspend_ack_ctrl_pkg.sv
// Purpose: shared state encoding, counter sizing and parameter checks for the suspend acknowledge controller.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package suspend_ack_pkg;

    // Controller states; the numeric values are visible in debug dumps, so keep them fixed.
    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DRAIN  = 3'd1,
        SETTLE = 3'd2,
        ACK    = 3'd3,
        RESUME = 3'd4
    } state_t;

    // Counter width for a counter that must be able to hold values up to p-1 with headroom.
    function automatic int cnt_w(input int p);
        return $clog2(p) + 1;
    endfunction

    // Legal parameter set: at least a two-flop synchronizer and non-zero durations.
    function automatic bit params_legal(input int sync_stages,
                                        input int settle_cycles,
                                        input int drain_timeout,
                                        input int resume_cycles);
        return (sync_stages >= 2) && (settle_cycles >= 1) &&
               (drain_timeout >= 1) && (resume_cycles >= 1);
    endfunction

endpackage

// File: rtl/suspend_ack_ctrl_if.sv
// Purpose: groups the suspend handshake and quiesce signals of the controller.
// Latency: none (wiring only).
// Backpressure: none; SREQ/SACK form a level handshake, HALT is the quiesce request.
// Ports: SREQ, BUSY, CLR_TIMEOUT toward the controller; HALT, SACK, SUSPENDED, TIMEOUT from it.
interface suspend_ack_ctrl_if;
    logic SREQ;
    logic BUSY;
    logic CLR_TIMEOUT;
    logic HALT;
    logic SACK;
    logic SUSPENDED;
    logic TIMEOUT;

    // master: the surroundings (suspend-sync primitive plus user datapath)
    modport master (
        output SREQ, BUSY, CLR_TIMEOUT,
        input  HALT, SACK, SUSPENDED, TIMEOUT
    );

    // slave: the controller itself
    modport slave (
        input  SREQ, BUSY, CLR_TIMEOUT,
        output HALT, SACK, SUSPENDED, TIMEOUT
    );
endinterface

// File: rtl/suspend_ack_ctrl_sreq_sync.sv
// Purpose: multi-flop synchronizer bringing the asynchronous SREQ into the CLK domain.
// Latency: q equals d delayed by SYNC_STAGES rising edges.
// Backpressure: none.
// Ports: CLK, RST (sync, active-high, clears every stage to 0), d (async in), q (synchronized out).
module suspend_sreq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/suspend_ack_ctrl.sv
// Purpose: user-side suspend controller: halt new work, drain, settle, acknowledge; release after wake.
// Latency: HALT rises SYNC_STAGES edges after SREQ is first sampled high; SACK drops SYNC_STAGES edges after SREQ falls.
// Backpressure: HALT stalls the user datapath; BUSY holds off SACK until drained or the drain timeout fires.
// Ports: CLK, RST (sync, active-high), sif (slave modport: SREQ, BUSY, CLR_TIMEOUT in; HALT, SACK, SUSPENDED, TIMEOUT out).
module suspend_ack_ctrl
    import suspend_ack_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int RESUME_CYCLES = 8
) (
    input  logic               CLK,
    input  logic               RST,
    suspend_ack_ctrl_if.slave  sif
);

    if (!params_legal(SYNC_STAGES, SETTLE_CYCLES, DRAIN_TIMEOUT, RESUME_CYCLES)) begin : g_bad_params
        $error("suspend_ack_ctrl: illegal parameter set");
    end

    localparam int DW = cnt_w(DRAIN_TIMEOUT);
    localparam int SW = cnt_w(SETTLE_CYCLES);
    localparam int RW = cnt_w(RESUME_CYCLES);

    localparam logic [DW-1:0] DRAIN_MAX  = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RESUME_MAX = RW'(RESUME_CYCLES - 1);

    logic            sreq_s;
    state_t          state, state_nxt;
    logic [DW-1:0]   drain_cnt, drain_nxt, drain_inc;
    logic [SW-1:0]   settle_cnt, settle_nxt, settle_inc;
    logic [RW-1:0]   resume_cnt, resume_nxt, resume_inc;
    logic            to_ep, to_ep_nxt;
    logic            to_set;
    logic            timeout_q, timeout_nxt;
    logic            halt_q, ack_q;

    suspend_sreq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sreq_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (sif.SREQ),
        .q   (sreq_s)
    );

    // Saturating increments; every terminal test is an equality so nothing can wrap past it.
    assign drain_inc  = (drain_cnt  == DRAIN_MAX)  ? drain_cnt  : drain_cnt  + DW'(1);
    assign settle_inc = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + SW'(1);
    assign resume_inc = (resume_cnt == RESUME_MAX) ? resume_cnt : resume_cnt + RW'(1);

    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        settle_nxt = settle_cnt;
        resume_nxt = resume_cnt;
        to_ep_nxt  = to_ep;
        to_set     = 1'b0;

        unique case (state)
            RUN: begin
                if (sreq_s) begin
                    state_nxt  = DRAIN;
                    drain_nxt  = '0;
                    settle_nxt = '0;
                    to_ep_nxt  = 1'b0;
                end
            end

            DRAIN: begin
                // The drain count includes the current cycle, so the forced
                // acknowledge fires on the cycle the count reaches its limit.
                drain_nxt = drain_inc;
                if (!sreq_s) begin
                    state_nxt = RUN;
                end else if (!sif.BUSY) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end else if (drain_inc == DRAIN_MAX) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                    to_ep_nxt  = 1'b1;
                    to_set     = 1'b1;
                end
            end

            SETTLE: begin
                settle_nxt = settle_inc;
                if (!sreq_s) begin
                    state_nxt = RUN;
                end else if (sif.BUSY && !to_ep) begin
                    // New activity restarts the drain; after a timeout BUSY is no longer trusted.
                    state_nxt  = DRAIN;
                    settle_nxt = '0;
                end else if (settle_cnt == SETTLE_MAX) begin
                    state_nxt = ACK;
                end
            end

            ACK: begin
                if (!sreq_s) begin
                    state_nxt  = RESUME;
                    resume_nxt = '0;
                end
            end

            RESUME: begin
                // SREQ is deliberately not looked at here; RUN picks it up on the next edge.
                resume_nxt = resume_inc;
                if (resume_cnt == RESUME_MAX) begin
                    state_nxt = RUN;
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // A set in the same cycle as a clear must win so a forced acknowledge is never lost.
    assign timeout_nxt = to_set ? 1'b1 : (sif.CLR_TIMEOUT ? 1'b0 : timeout_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            drain_cnt  <= '0;
            settle_cnt <= '0;
            resume_cnt <= '0;
            to_ep      <= 1'b0;
            timeout_q  <= 1'b0;
            halt_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_nxt;
            settle_cnt <= settle_nxt;
            resume_cnt <= resume_nxt;
            to_ep      <= to_ep_nxt;
            timeout_q  <= timeout_nxt;
            // Outputs are flopped from the next state so they track the state register exactly.
            halt_q     <= (state_nxt != RUN);
            ack_q      <= (state_nxt == ACK);
        end
    end

    assign sif.HALT      = halt_q;
    assign sif.SACK      = ack_q;
    assign sif.SUSPENDED = ack_q;
    assign sif.TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_suspend_ack_ctrl.sv
// Purpose: directed, table-driven bench for suspend_ack_ctrl with default parameters.
// Latency: edges are counted from 1 after each reset release; checks sample 1 time unit after an edge.
// Backpressure: not applicable.
module tb_suspend_ack_ctrl;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    suspend_ack_ctrl_if sif ();

    suspend_ack_ctrl #(
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (16),
        .DRAIN_TIMEOUT (1024),
        .RESUME_CYCLES (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .sif (sif.slave)
    );

    // One record: optionally reset first, advance to just after edge e, check the
    // outputs, then drive the inputs that the next edge (e+1) will sample.
    typedef struct {
        int e;
        bit rst_first;
        bit rst;
        bit sreq;
        bit busy;
        bit clr;
        bit halt;
        bit sack;
        bit to;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic vec_t v(int e, bit r0, bit rst, bit sreq, bit busy, bit clr,
                               bit halt, bit sack, bit to);
        vec_t r;
        r.e = e; r.rst_first = r0; r.rst = rst;
        r.sreq = sreq; r.busy = busy; r.clr = clr;
        r.halt = halt; r.sack = sack; r.to = to;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic goto(input int e);
        while (cyc < e) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        sif.SREQ = 1'b0;
        sif.BUSY = 1'b0;
        sif.CLR_TIMEOUT = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        cyc = 0;
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d edge %0d: got %b expected %b", name, idx, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sack(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (sif.SACK === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int a;
        int t_ack;

        RST = 1'b1;
        sif.SREQ = 1'b0;
        sif.BUSY = 1'b0;
        sif.CLR_TIMEOUT = 1'b0;

        //           e     r0 rst sreq busy clr  halt sack to
        // Clean suspend then wake
        vecs.push_back(v(   0, 1, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(v(   9, 0, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(v(  11, 0, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(v(  12, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  28, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  29, 0, 0, 1, 0, 0,  1, 1, 0));
        vecs.push_back(v(  99, 0, 0, 0, 0, 0,  1, 1, 0));
        vecs.push_back(v( 101, 0, 0, 0, 0, 0,  1, 1, 0));
        vecs.push_back(v( 102, 0, 0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(v( 109, 0, 0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(v( 110, 0, 0, 0, 0, 0,  0, 0, 0));
        // Busy drain: BUSY first sampled low at edge 51; BUSY ignored once in ACK
        vecs.push_back(v(   0, 1, 0, 0, 1, 0,  0, 0, 0));
        vecs.push_back(v(   9, 0, 0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(v(  12, 0, 0, 1, 1, 0,  1, 0, 0));
        vecs.push_back(v(  50, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  66, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  67, 0, 0, 1, 1, 0,  1, 1, 0));
        vecs.push_back(v(  70, 0, 0, 1, 1, 0,  1, 1, 0));
        // Busy pulse sampled at edge 55 while settling sends it back to DRAIN
        vecs.push_back(v(   0, 1, 0, 0, 1, 0,  0, 0, 0));
        vecs.push_back(v(   9, 0, 0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(v(  50, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  54, 0, 0, 1, 1, 0,  1, 0, 0));
        vecs.push_back(v(  55, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  71, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  72, 0, 0, 1, 0, 0,  1, 1, 0));
        // Drain timeout with clear coincident with the set, then clear after resume
        vecs.push_back(v(   0, 1, 0, 0, 1, 0,  0, 0, 0));
        vecs.push_back(v(   9, 0, 0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(v(  12, 0, 0, 1, 1, 0,  1, 0, 0));
        vecs.push_back(v(1034, 0, 0, 1, 1, 1,  1, 0, 0));
        vecs.push_back(v(1035, 0, 0, 1, 1, 0,  1, 0, 1));
        vecs.push_back(v(1050, 0, 0, 1, 1, 0,  1, 0, 1));
        vecs.push_back(v(1051, 0, 0, 1, 1, 0,  1, 1, 1));
        vecs.push_back(v(1054, 0, 0, 0, 1, 0,  1, 1, 1));
        vecs.push_back(v(1065, 0, 0, 0, 1, 1,  0, 0, 1));
        vecs.push_back(v(1066, 0, 0, 0, 1, 0,  0, 0, 0));
        vecs.push_back(v(1070, 0, 0, 0, 1, 0,  0, 0, 0));
        // Abort from SETTLE: never acknowledges
        vecs.push_back(v(   0, 1, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(v(   9, 0, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(v(  13, 0, 0, 1, 0, 0,  1, 0, 0));
        vecs.push_back(v(  19, 0, 0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(v(  21, 0, 0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(v(  22, 0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(v(  29, 0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(v(  30, 0, 0, 0, 0, 0,  0, 0, 0));
        // Reset mid-DRAIN with SREQ held high
        vecs.push_back(v(   0, 1, 0, 0, 1, 0,  0, 0, 0));
        vecs.push_back(v(   9, 0, 0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(v(  12, 0, 0, 1, 1, 0,  1, 0, 0));
        vecs.push_back(v(  39, 0, 1, 1, 1, 0,  1, 0, 0));
        vecs.push_back(v(  40, 0, 0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(v(  42, 0, 0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(v(  43, 0, 0, 1, 1, 0,  1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) do_reset();
            goto(vecs[i].e);
            chk("HALT",      i, sif.HALT,      vecs[i].halt);
            chk("SACK",      i, sif.SACK,      vecs[i].sack);
            chk("SUSPENDED", i, sif.SUSPENDED, vecs[i].sack);
            chk("TIMEOUT",   i, sif.TIMEOUT,   vecs[i].to);
            RST             = vecs[i].rst;
            sif.SREQ        = vecs[i].sreq;
            sif.BUSY        = vecs[i].busy;
            sif.CLR_TIMEOUT = vecs[i].clr;
        end

        // SREQ re-raised during RESUME: one RUN cycle, then DRAIN again.
        do_reset();
        sif.SREQ = 1'b1;
        wait_sack(1'b1, 100, ok);
        chk_int("ack_rise_seen", int'(ok), 1);
        chk_int("ack_rise_edge", cyc, 20);
        sif.SREQ = 1'b0;
        wait_sack(1'b0, 20, ok);
        chk_int("ack_fall_seen", int'(ok), 1);
        a = cyc;
        chk_int("ack_fall_edge", a, 23);
        sif.SREQ = 1'b1;
        goto(a + 7);
        chk("resume_halt_hold", 0, sif.HALT, 1'b1);
        goto(a + 8);
        chk("resume_to_run",    0, sif.HALT, 1'b0);
        goto(a + 9);
        chk("run_to_drain",     0, sif.HALT, 1'b1);
        goto(a + 25);
        chk("reack_early",      0, sif.SACK, 1'b0);
        wait_sack(1'b1, 20, ok);
        chk_int("reack_seen", int'(ok), 1);
        t_ack = cyc;
        chk_int("reack_edge", t_ack, a + 26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
